// File: rtl/fp32_pkg.sv
// Shared binary32 field definitions, constants and operand classification
// used by the multiply, add/sub and divide units.
package fp32_pkg;

   localparam int EXP_W  = 8;
   localparam int FRAC_W = 23;
   localparam int WORD_W = 1 + EXP_W + FRAC_W;
   localparam int SIG_W  = FRAC_W + 1;
   localparam int PROD_W = 2 * SIG_W;
   localparam int XEXP_W = 10;
   localparam int BIAS   = 127;

   localparam logic [WORD_W-1:0] QNAN    = 32'h7FC0_0000;
   localparam logic [EXP_W-1:0]  EXP_MAX = 8'hFF;

   typedef struct packed {
      logic              sign;
      logic [EXP_W-1:0]  exp;
      logic [FRAC_W-1:0] frac;
   } fp32_t;

   typedef struct packed {
      logic is_nan;
      logic is_inf;
      logic is_zero;
   } fp_class_t;

   typedef enum logic [1:0] {
      SEL_NORM,
      SEL_NAN,
      SEL_INF,
      SEL_ZERO
   } res_sel_t;

   // Subnormals (exp=0, frac!=0) are deliberately classed as zero.
   function automatic fp_class_t classify(input fp32_t x);
      fp_class_t c;
      c.is_nan  = (x.exp == EXP_MAX) && (x.frac != '0);
      c.is_inf  = (x.exp == EXP_MAX) && (x.frac == '0);
      c.is_zero = (x.exp == '0);
      return c;
   endfunction

   function automatic logic [WORD_W-1:0] pack_inf(input logic sign);
      return {sign, EXP_MAX, {FRAC_W{1'b0}}};
   endfunction

   function automatic logic [WORD_W-1:0] pack_zero(input logic sign);
      return {sign, {(WORD_W-1){1'b0}}};
   endfunction

endpackage

// File: rtl/fp_mul_v2_if.sv
// Operand/result bundle between the operand registers and the multiplier.
interface fp_mul_v2_if;
   import fp32_pkg::*;

   logic              in_valid;
   logic [WORD_W-1:0] in1;
   logic [WORD_W-1:0] in2;
   logic              out_valid;
   logic [WORD_W-1:0] out;

   modport master (
      output in_valid,
      output in1,
      output in2,
      input  out_valid,
      input  out
   );

   modport slave (
      input  in_valid,
      input  in1,
      input  in2,
      output out_valid,
      output out
   );

endinterface

// File: rtl/fp32_round_norm.sv
// Normalizes a 48-bit significand product, rounds to nearest-even and
// resolves overflow to infinity and underflow to signed zero.
module fp32_round_norm
   import fp32_pkg::*;
(
   input  logic [PROD_W-1:0]        prod_i,
   input  logic signed [XEXP_W-1:0] exp_i,
   input  logic                     sign_i,
   output logic [WORD_W-1:0]        res_o
);

   logic [FRAC_W-1:0]        frac_t;
   logic                     guard;
   logic                     sticky;
   logic                     round_up;
   logic [FRAC_W:0]          frac_r;
   logic signed [XEXP_W-1:0] exp_n;
   logic signed [XEXP_W-1:0] exp_r;

   always_comb begin
      // Product of two [1,2) significands lies in [1,4); bit 47 picks the scale.
      if (prod_i[47]) begin
         frac_t = prod_i[46:24];
         guard  = prod_i[23];
         sticky = |prod_i[22:0];
         exp_n  = exp_i + 10'sd1;
      end else begin
         frac_t = prod_i[45:23];
         guard  = prod_i[22];
         sticky = |prod_i[21:0];
         exp_n  = exp_i;
      end

      round_up = guard & (sticky | frac_t[0]);
      frac_r   = {1'b0, frac_t} + {{FRAC_W{1'b0}}, round_up};

      // On carry-out the low fraction bits are already zero, i.e. mantissa 1.0.
      exp_r = exp_n + $signed({{(XEXP_W-1){1'b0}}, frac_r[FRAC_W]});

      if (exp_r >= 10'sd255) begin
         res_o = pack_inf(sign_i);
      end else if (exp_r <= 10'sd0) begin
         res_o = pack_zero(sign_i);
      end else begin
         res_o = {sign_i, exp_r[EXP_W-1:0], frac_r[FRAC_W-1:0]};
      end
   end

endmodule

// File: rtl/fp_mul_v2.sv
// Registered binary32 multiplier: one-cycle latency, full throughput,
// round-to-nearest-even with flush-to-zero for subnormal inputs and results.
module fp_mul_v2
   import fp32_pkg::*;
(
   input  logic        clk,
   input  logic        rst_n,
   fp_mul_v2_if.slave  bus
);

   fp32_t                    op_a;
   fp32_t                    op_b;
   fp_class_t                cls_a;
   fp_class_t                cls_b;
   logic                     res_sign;
   logic [SIG_W-1:0]         sig_a;
   logic [SIG_W-1:0]         sig_b;
   logic [PROD_W-1:0]        prod;
   logic signed [XEXP_W-1:0] exp_raw;
   logic [WORD_W-1:0]        norm_res;
   res_sel_t                 sel;
   logic [WORD_W-1:0]        out_d;
   logic [WORD_W-1:0]        out_q;
   logic                     out_valid_q;

   assign op_a     = bus.in1;
   assign op_b     = bus.in2;
   assign cls_a    = classify(op_a);
   assign cls_b    = classify(op_b);
   assign res_sign = op_a.sign ^ op_b.sign;

   assign sig_a   = {1'b1, op_a.frac};
   assign sig_b   = {1'b1, op_b.frac};
   assign prod    = PROD_W'(sig_a) * PROD_W'(sig_b);
   assign exp_raw = $signed(XEXP_W'(op_a.exp)) + $signed(XEXP_W'(op_b.exp))
                    - $signed(XEXP_W'(BIAS));

   fp32_round_norm u_round_norm (
      .prod_i (prod),
      .exp_i  (exp_raw),
      .sign_i (res_sign),
      .res_o  (norm_res)
   );

   // Special cases in priority order: NaN, Inf x 0, Inf, zero.
   always_comb begin
      sel = SEL_NORM;
      if (cls_a.is_nan || cls_b.is_nan) begin
         sel = SEL_NAN;
      end else if ((cls_a.is_inf && cls_b.is_zero) || (cls_a.is_zero && cls_b.is_inf)) begin
         sel = SEL_NAN;
      end else if (cls_a.is_inf || cls_b.is_inf) begin
         sel = SEL_INF;
      end else if (cls_a.is_zero || cls_b.is_zero) begin
         sel = SEL_ZERO;
      end
   end

   always_comb begin
      out_d = norm_res;
      case (sel)
         SEL_NAN:  out_d = QNAN;
         SEL_INF:  out_d = pack_inf(res_sign);
         SEL_ZERO: out_d = pack_zero(res_sign);
         default:  out_d = norm_res;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         out_q       <= '0;
         out_valid_q <= 1'b0;
      end else begin
         out_valid_q <= bus.in_valid;
         if (bus.in_valid) begin
            out_q <= out_d;
         end
      end
   end

   assign bus.out       = out_q;
   assign bus.out_valid = out_valid_q;

endmodule

// File: tb/tb_fp_mul_v2.sv
// Directed-vector bench for fp_mul_v2: streaming products, specials,
// range limits, valid gaps and mid-stream reset.
module tb_fp_mul_v2;

   logic clk = 1'b0;
   logic rst_n;

   always #5 clk = ~clk;

   fp_mul_v2_if bus ();

   fp_mul_v2 dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   int total_cnt = 0;
   int bad_cnt   = 0;

   localparam int NV = 19;

   logic [31:0] va [NV] = '{
      32'h40000000, 32'h40000000, 32'h40A80000, 32'hBF800000,
      32'h40200000, 32'h44FC7333, 32'h44FC7333, 32'h7F800000,
      32'hFF800000, 32'hFF800000, 32'h00000000, 32'h7F000000,
      32'h00800000, 32'h3D820817, 32'h80000000, 32'h00400000,
      32'h3F800001, 32'h3F800001, 32'h3F800003
   };
   logic [31:0] vb [NV] = '{
      32'h3F800000, 32'h40000000, 32'h40000000, 32'h40000000,
      32'h40600000, 32'hC0600000, 32'hFF800001, 32'h00000000,
      32'h7F800000, 32'hFF800000, 32'h00000000, 32'h40000000,
      32'h3F000000, 32'h352EB9ED, 32'h3F800000, 32'h40000000,
      32'h3F800001, 32'h3FC00000, 32'h3FC00000
   };
   logic [31:0] ve [NV] = '{
      32'h40000000, 32'h40800000, 32'h41280000, 32'hC0000000,
      32'h410C0000, 32'hC5DCE4CD, 32'h7FC00000, 32'h7FC00000,
      32'hFF800000, 32'h7F800000, 32'h00000000, 32'h7F800000,
      32'h00000000, 32'h33317FE0, 32'h80000000, 32'h00000000,
      32'h3F800002, 32'h3FC00002, 32'h3FC00004
   };

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
      total_cnt++;
      if (got !== want) begin
         bad_cnt++;
         $display("FAIL %s: got=%h want=%h", tag, got, want);
      end
   endtask

   task automatic drive(input logic v, input logic [31:0] a, input logic [31:0] b);
      bus.in_valid = v;
      bus.in1      = a;
      bus.in2      = b;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      // Reset must win over a valid operand pair.
      rst_n = 1'b0;
      drive(1'b1, 32'h40000000, 32'h40000000);
      @(negedge clk);
      @(negedge clk);
      check_eq("rst_out", bus.out, 32'h0);
      check_eq("rst_vld", {31'b0, bus.out_valid}, 32'h0);
      $display("reset: out=%h out_valid=%b", bus.out, bus.out_valid);

      rst_n = 1'b1;
      drive(1'b0, 32'h0, 32'h0);
      @(negedge clk);
      check_eq("idle_vld", {31'b0, bus.out_valid}, 32'h0);

      // Back-to-back stream: each result is due exactly one edge later.
      for (int i = 0; i <= NV; i++) begin
         if (i < NV) begin
            drive(1'b1, va[i], vb[i]);
         end else begin
            drive(1'b0, 32'h0, 32'h0);
         end
         @(negedge clk);
         if (i < NV) begin
            check_eq($sformatf("vec%0d", i), bus.out, ve[i]);
            check_eq($sformatf("vec%0d_vld", i), {31'b0, bus.out_valid}, 32'h1);
            $display("vec %0d: %h x %h -> %h (want %h)", i, va[i], vb[i], bus.out, ve[i]);
         end
      end
      check_eq("gap_vld", {31'b0, bus.out_valid}, 32'h0);
      check_eq("gap_hold", bus.out, ve[NV-1]);
      $display("gap: out=%h out_valid=%b", bus.out, bus.out_valid);

      drive(1'b1, va[4], vb[4]);
      @(negedge clk);
      check_eq("after_gap", bus.out, ve[4]);
      check_eq("after_gap_vld", {31'b0, bus.out_valid}, 32'h1);
      $display("after gap: out=%h out_valid=%b", bus.out, bus.out_valid);

      // Mid-stream reset with a valid pair presented on the same edge.
      rst_n = 1'b0;
      drive(1'b1, va[5], vb[5]);
      @(negedge clk);
      check_eq("mid_rst_out", bus.out, 32'h0);
      check_eq("mid_rst_vld", {31'b0, bus.out_valid}, 32'h0);
      $display("mid reset: out=%h out_valid=%b", bus.out, bus.out_valid);

      rst_n = 1'b1;
      drive(1'b1, va[11], vb[11]);
      @(negedge clk);
      check_eq("post_rst", bus.out, ve[11]);
      check_eq("post_rst_vld", {31'b0, bus.out_valid}, 32'h1);
      $display("post reset: out=%h out_valid=%b", bus.out, bus.out_valid);

      drive(1'b0, 32'h3F800000, 32'h3F800000);
      @(negedge clk);
      check_eq("final_hold", bus.out, ve[11]);
      check_eq("final_vld", {31'b0, bus.out_valid}, 32'h0);
      $display("idle: out=%h out_valid=%b", bus.out, bus.out_valid);

      $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
      $finish;
   end

endmodule
